// File: rtl/sram_flit_source.sv
// Reads a block of SRAM words and emits one HF/BF/TF triple per word; 3 cycles/flit, first flit 3 cycles after start.
// Holds the triple while flit_ready is low. Define FLIT_CHECKSUM_EN to carry a running XOR checksum in TF[7:0].
module sram_flit_source #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        src_addr,
    input  logic [7:0]        dest_addr,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [15:0]       sram_data_in,
    output logic [15:0]       HF,
    output logic [15:0]       BF,
    output logic [15:0]       TF,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic              flit_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_HOLD, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [7:0]        r_seq;
    logic [7:0]        r_src;
    logic [7:0]        r_dest;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [15:0]       r_hf;
    logic [15:0]       r_bf;
    logic [15:0]       r_tf;
    logic              r_last;
    logic              w_accept;
    logic              w_hs;
    logic              w_more;
    logic [7:0]        w_tf_lo;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_hs     = (r_state == S_HOLD) && flit_ready;
    assign w_more   = r_remaining > LEN_W'(1);

`ifdef FLIT_CHECKSUM_EN
    logic [7:0] r_cksum;
    logic [7:0] w_cksum_next;

    assign w_cksum_next = r_cksum ^ sram_data_in[15:8] ^ sram_data_in[7:0];
    assign w_tf_lo      = w_cksum_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cksum <= 8'h00;
        end else if (w_accept) begin
            r_cksum <= 8'h00;
        end else if (r_state == S_WAIT) begin
            r_cksum <= w_cksum_next;
        end
    end
`else
    assign w_tf_lo = 8'h00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        flit_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (length != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: w_next = S_WAIT;
            S_WAIT: w_next = S_HOLD;
            S_HOLD: begin
                flit_valid = 1'b1;
                if (flit_ready) begin
                    w_next = w_more ? S_READ : S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Read strobe and address are registered so the address holds steady outside READ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_seq       <= 8'h00;
            r_src       <= 8'h00;
            r_dest      <= 8'h00;
            r_rd_en     <= 1'b0;
            r_sram_addr <= '0;
            r_hf        <= 16'h0000;
            r_bf        <= 16'h0000;
            r_tf        <= 16'h0000;
            r_last      <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= length;
                r_src       <= src_addr;
                r_dest      <= dest_addr;
                r_seq       <= 8'h00;
                if (length != '0) begin
                    r_rd_en     <= 1'b1;
                    r_sram_addr <= base_addr;
                end
            end else if (w_hs) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
                r_seq       <= r_seq + 8'd1;
                if (w_more) begin
                    r_rd_en     <= 1'b1;
                    r_sram_addr <= r_addr + ADDR_W'(1);
                end
            end
            if (r_state == S_WAIT) begin
                r_hf   <= {r_dest, r_src};
                r_bf   <= sram_data_in;
                r_tf   <= {r_seq, w_tf_lo};
                r_last <= (r_remaining == LEN_W'(1));
            end
        end
    end

    assign sram_rd_en = r_rd_en;
    assign sram_addr  = r_sram_addr;
    assign HF         = r_hf;
    assign BF         = r_bf;
    assign TF         = r_tf;
    assign flit_last  = r_last;

endmodule

// File: tb/tb_sram_flit_source.sv
// Bench for sram_flit_source: table of transfers checked against a word-level model, plus reset/checksum sequences.
module tb_sram_flit_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [7:0]  length;
    logic [7:0]  src_addr;
    logic [7:0]  dest_addr;
    logic        sram_rd_en;
    logic [9:0]  sram_addr;
    logic [15:0] sram_data_in = 16'h0000;
    logic [15:0] HF, BF, TF;
    logic        flit_valid;
    logic        flit_ready;
    logic        flit_last;
    logic        busy;
    logic        done;

    sram_flit_source dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .src_addr(src_addr), .dest_addr(dest_addr), .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
        .sram_data_in(sram_data_in), .HF(HF), .BF(BF), .TF(TF), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .flit_last(flit_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    always @(posedge clk) if (sram_rd_en) sram_data_in <= mem[sram_addr];

    typedef struct {
        logic [9:0] base;
        int         len;
        logic [7:0] src;
        logic [7:0] dest;
        int         mode;      // 0 ready high, 1 random ready, 2 stall flit 2 for 5 cycles, 3 ready high + start while busy
        int         exp_done;  // cycle of done pulse after the start edge; 0 = not fixed
    } vec_t;

    vec_t        tv [10];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] tf_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!flit_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!flit_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: flit_valid not seen within 50 cycles", name);
        end
    endtask

    task automatic run(input vec_t v);
        logic [15:0] exp_bf [$];
        logic [15:0] exp_tf [$];
        logic [7:0]  ck = 8'h00;
        logic [15:0] w;
        logic [9:0]  a;
        int cyc = 1, rd_cnt = 0, fl = 0, first_v = -1, done_cnt = 0, done_cyc = -1;
        int busy_cnt = 0, valid_cnt = 0, stall = 0;
        bit fin = 0;
        bit r;
        for (int k = 0; k < v.len; k++) begin
            a = 10'(v.base + 10'(k));
            w = mem[a];
            ck = ck ^ w[15:8] ^ w[7:0];
            exp_bf.push_back(w);
`ifdef FLIT_CHECKSUM_EN
            exp_tf.push_back({8'(k), ck});
`else
            exp_tf.push_back({8'(k), 8'h00});
`endif
        end
        tf_log.delete();
        @(negedge clk);
        base_addr = v.base; length = 8'(v.len); src_addr = v.src; dest_addr = v.dest;
        start = 1'b1; flit_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 2000) begin
            if (busy) busy_cnt++;
            if (sram_rd_en) begin
                chk("rd_addr", 64'(sram_addr), 64'(10'(v.base + 10'(rd_cnt))));
                rd_cnt++;
            end
            if (flit_valid) begin
                valid_cnt++;
                if (first_v < 0) first_v = cyc;
                if (fl < v.len) begin
                    chk("flit", {HF, BF, TF, flit_last},
                        {v.dest, v.src, exp_bf[fl], exp_tf[fl], (fl == v.len - 1)});
                end else begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL flit_extra: flit %0d offered, only %0d expected", fl, v.len);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                fin = 1;
            end
            case (v.mode)
                1: r = 1'($urandom_range(0, 1));
                2: begin
                    r = !(flit_valid && fl == 1 && stall < 5);
                    if (!r) stall++;
                end
                default: r = 1'b1;
            endcase
            flit_ready = r;
            if (flit_valid && r) begin
                tf_log.push_back(TF);
                fl++;
            end
            if (v.mode == 3 && cyc == 2) begin
                start = 1'b1;
                base_addr = 10'($urandom); length = 8'($urandom_range(1, 255));
                src_addr = 8'($urandom); dest_addr = 8'($urandom);
            end
            if (cyc == 3) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no done within %0d cycles", cyc);
        end
        chk("done_cnt", 64'(done_cnt), 64'd1);
        chk("rd_cnt", 64'(rd_cnt), 64'(v.len));
        chk("flit_cnt", 64'(fl), 64'(v.len));
        chk("first_valid", 64'(first_v), (v.len > 0) ? 64'd3 : 64'(-1));
        if (v.exp_done != 0) begin
            chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
            chk("busy_cycles", 64'(busy_cnt), 64'(v.exp_done));
        end
        if (v.mode != 1) chk("valid_cycles", 64'(valid_cnt), 64'(v.len + ((v.mode == 2) ? 5 : 0)));
        chk("idle_after", {busy, flit_valid, done, sram_rd_en}, 4'b0000);
    endtask

    initial begin
        int t;
        int dn;
        int rdn;
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        src_addr = '0; dest_addr = '0; flit_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[10'h010] = 16'h1111; mem[10'h011] = 16'h2222; mem[10'h012] = 16'h3333;
        mem[10'h040] = 16'h1234; mem[10'h041] = 16'h00FF;

        tv[0] = '{10'h010, 3, 8'h01, 8'h05, 0, 10};
        tv[1] = '{10'h010, 3, 8'h01, 8'h05, 2, 15};
        tv[2] = '{10'h3FF, 2, 8'hAA, 8'h55, 0, 7};
        tv[3] = '{10'h123, 0, 8'h12, 8'h34, 0, 1};
        for (int i = 4; i < 8; i++)
            tv[i] = '{10'($urandom), int'($urandom_range(1, 12)), 8'($urandom), 8'($urandom), 1, 0};
        tv[8] = '{10'h200, 4, 8'h33, 8'h44, 3, 13};
        tv[9] = '{10'h3F0, 255, 8'h9C, 8'hE7, 0, 766};

        #1;
        chk("reset_outputs", {sram_rd_en, sram_addr, HF, BF, TF, flit_valid, flit_last, busy, done}, 62'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run(tv[i]);
            if (i == 0) begin
                chk("tf_log_size", 64'(tf_log.size()), 64'd3);
                if (tf_log.size() == 3)
                    chk("tf_seq", {tf_log[0], tf_log[1], tf_log[2]}, {16'h0000, 16'h0100, 16'h0200});
            end
        end

        // Reset while flit 2 of 3 is held.
        @(negedge clk);
        base_addr = 10'h010; length = 8'd3; src_addr = 8'h01; dest_addr = 8'h05;
        start = 1'b1; flit_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("rst_flit1");
        @(negedge clk);
        flit_ready = 1'b0;
        wait_valid("rst_flit2");
        chk("rst_pre_bf", 64'(BF), 64'h2222);
        reset = 1'b1;
        #1;
        chk("rst_outputs", {sram_rd_en, sram_addr, HF, BF, TF, flit_valid, flit_last, busy, done}, 62'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0; rdn = 0;
        for (t = 0; t < 10; t++) begin
            if (done) dn++;
            if (sram_rd_en || busy) rdn++;
            @(negedge clk);
        end
        chk("rst_no_done", 64'(dn), 64'd0);
        chk("rst_no_activity", 64'(rdn), 64'd0);
        run('{10'h011, 1, 8'h01, 8'h05, 0, 4});
        if (tf_log.size() == 1) chk("rst_seq_restart", 64'(tf_log[0]), 64'h0000);
        else chk("rst_seq_restart_cnt", 64'(tf_log.size()), 64'd1);

        // Checksum words 0x1234, 0x00FF.
        run('{10'h040, 2, 8'h07, 8'h08, 0, 7});
        if (tf_log.size() == 2) begin
`ifdef FLIT_CHECKSUM_EN
            chk("cksum_tf", {tf_log[0], tf_log[1]}, {16'h0026, 16'h01D9});
`else
            chk("cksum_tf", {tf_log[0], tf_log[1]}, {16'h0000, 16'h0100});
`endif
        end else begin
            chk("cksum_tf_cnt", 64'(tf_log.size()), 64'd2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
